// File: rtl/coder_axil_regbank.sv
// coder_axil_regbank: AXI4-Lite slave register bank for the coder IP.
// Holds C_NUM_REGS 32-bit registers with per-byte write strobes. Registers
// flagged in C_RO_MASK are read-only views of hw_in. A one-cycle wr_pulse
// is raised for every committed write so the datapath can react to updates.
module coder_axil_regbank #(
    parameter int                    C_S_AXI_DATA_WIDTH = 32,
    parameter int                    C_S_AXI_ADDR_WIDTH = 6,
    parameter int                    C_NUM_REGS         = 8,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0
) (
    input  logic                                     s00_axi_aclk,
    input  logic                                     s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_awaddr,
    input  logic [2:0]                               s00_axi_awprot,
    input  logic                                     s00_axi_awvalid,
    output logic                                     s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          s00_axi_wstrb,
    input  logic                                     s00_axi_wvalid,
    output logic                                     s00_axi_wready,
    output logic [1:0]                               s00_axi_bresp,
    output logic                                     s00_axi_bvalid,
    input  logic                                     s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_araddr,
    input  logic [2:0]                               s00_axi_arprot,
    input  logic                                     s00_axi_arvalid,
    output logic                                     s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_rdata,
    output logic [1:0]                               s00_axi_rresp,
    output logic                                     s00_axi_rvalid,
    input  logic                                     s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH*C_NUM_REGS-1:0] reg_out,
    input  logic [C_S_AXI_DATA_WIDTH*C_NUM_REGS-1:0] hw_in,
    output logic [C_NUM_REGS-1:0]                    wr_pulse
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    // ---------------- storage and channel state ----------------
    logic [DW-1:0]         regs_q [C_NUM_REGS];

    w_state_t              w_state_reg, w_state_next;
    logic                  awready_reg, awready_next;
    logic                  wready_reg, wready_next;
    logic                  aw_held_reg, aw_held_next;
    logic                  w_held_reg, w_held_next;
    logic                  bvalid_reg, bvalid_next;
    logic [1:0]            bresp_reg, bresp_next;
    logic [C_NUM_REGS-1:0] wr_pulse_reg, wr_pulse_next;
    logic [IW-1:0]         aw_idx_reg;
    logic [DW-1:0]         wdata_reg;
    logic [NB-1:0]         wstrb_reg;

    r_state_t              r_state_reg, r_state_next;
    logic                  arready_reg, arready_next;
    logic                  rvalid_reg, rvalid_next;
    logic [1:0]            rresp_reg, rresp_next;
    logic [DW-1:0]         rdata_reg, rdata_next;

    // ---------------- write-side decode ----------------
    logic                  aw_hs, w_hs, aw_got, w_got, wr_commit, wr_ok;
    logic [IW-1:0]         wr_idx;
    logic [DW-1:0]         wr_data;
    logic [NB-1:0]         wr_strb;
    logic [C_NUM_REGS-1:0] wr_hit;

    assign aw_hs  = s00_axi_awvalid & awready_reg;
    assign w_hs   = s00_axi_wvalid & wready_reg;
    assign aw_got = aw_held_reg | aw_hs;
    assign w_got  = w_held_reg | w_hs;

    // A channel captured in the current cycle bypasses its holding register
    assign wr_idx  = aw_hs ? s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_reg;
    assign wr_data = w_hs ? s00_axi_wdata : wdata_reg;
    assign wr_strb = w_hs ? s00_axi_wstrb : wstrb_reg;

    // ---------------- read-side decode ----------------
    logic                  ar_hs, rd_in_range;
    logic [IW-1:0]         rd_idx;
    logic [C_NUM_REGS-1:0] rd_hit;
    logic [DW-1:0]         rd_word;

    assign ar_hs  = s00_axi_arvalid & arready_reg;
    assign rd_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    // Per-register address decode and reg_out mapping
    for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
        assign wr_hit[gi] = (wr_idx == IW'(gi));
        assign rd_hit[gi] = (rd_idx == IW'(gi));
        if (C_RO_MASK[gi]) begin : g_ro
            assign reg_out[DW*gi +: DW] = '0;
        end else begin : g_rw
            assign reg_out[DW*gi +: DW] = regs_q[gi];
        end
    end

    // An index outside the bank never hits, so this also rejects out-of-range writes
    assign wr_ok       = |(wr_hit & ~C_RO_MASK);
    assign rd_in_range = |rd_hit;

    // Read data mux: RO registers reflect hw_in live, others the stored value
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (rd_hit[i]) begin
                rd_word = C_RO_MASK[i] ? hw_in[DW*i +: DW] : regs_q[i];
            end
        end
    end

    // Write FSM next-state: collect AW and W in any order, commit when both present
    always_comb begin
        w_state_next  = w_state_reg;
        awready_next  = awready_reg;
        wready_next   = wready_reg;
        aw_held_next  = aw_held_reg;
        w_held_next   = w_held_reg;
        bvalid_next   = bvalid_reg;
        bresp_next    = bresp_reg;
        wr_commit     = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_got && w_got) begin
                    wr_commit    = 1'b1;
                    w_state_next = W_RESP;
                    bvalid_next  = 1'b1;
                    bresp_next   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                    awready_next = 1'b0;
                    wready_next  = 1'b0;
                end else begin
                    aw_held_next = aw_got;
                    w_held_next  = w_got;
                    awready_next = !aw_got;
                    wready_next  = !w_got;
                end
            end
            W_RESP: begin
                awready_next = 1'b0;
                wready_next  = 1'b0;
                if (bvalid_reg && s00_axi_bready) begin
                    w_state_next = W_IDLE;
                    bvalid_next  = 1'b0;
                    awready_next = 1'b1;
                    wready_next  = 1'b1;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
        wr_pulse_next = (wr_commit && wr_ok) ? wr_hit : '0;
    end

    // Write FSM state, handshake outputs and captured AW/W payloads
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            w_state_reg  <= W_IDLE;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            wr_pulse_reg <= '0;
            aw_idx_reg   <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
        end else begin
            w_state_reg  <= w_state_next;
            awready_reg  <= awready_next;
            wready_reg   <= wready_next;
            aw_held_reg  <= aw_held_next;
            w_held_reg   <= w_held_next;
            bvalid_reg   <= bvalid_next;
            bresp_reg    <= bresp_next;
            wr_pulse_reg <= wr_pulse_next;
            if (aw_hs) begin
                aw_idx_reg <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                wdata_reg <= s00_axi_wdata;
                wstrb_reg <= s00_axi_wstrb;
            end
        end
    end

    // Register file update: byte lanes with strobe set take the new data
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_hit[i] && !C_RO_MASK[i]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_strb[b]) begin
                            regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read FSM next-state: capture data on AR handshake, hold until R handshake
    always_comb begin
        r_state_next = r_state_reg;
        arready_next = arready_reg;
        rvalid_next  = rvalid_reg;
        rresp_next   = rresp_reg;
        rdata_next   = rdata_reg;
        case (r_state_reg)
            R_IDLE: begin
                arready_next = 1'b1;
                if (ar_hs) begin
                    r_state_next = R_DATA;
                    arready_next = 1'b0;
                    rvalid_next  = 1'b1;
                    rdata_next   = rd_word;
                    rresp_next   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                arready_next = 1'b0;
                if (rvalid_reg && s00_axi_rready) begin
                    r_state_next = R_IDLE;
                    rvalid_next  = 1'b0;
                    arready_next = 1'b1;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read FSM state and registered read response
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            r_state_reg <= r_state_next;
            arready_reg <= arready_next;
            rvalid_reg  <= rvalid_next;
            rresp_reg   <= rresp_next;
            rdata_reg   <= rdata_next;
        end
    end

    assign s00_axi_awready = awready_reg;
    assign s00_axi_wready  = wready_reg;
    assign s00_axi_bvalid  = bvalid_reg;
    assign s00_axi_bresp   = bresp_reg;
    assign s00_axi_arready = arready_reg;
    assign s00_axi_rvalid  = rvalid_reg;
    assign s00_axi_rresp   = rresp_reg;
    assign s00_axi_rdata   = rdata_reg;
    assign wr_pulse        = wr_pulse_reg;

    // Protection bits, byte offset and RW-slot status inputs carry no meaning here
    logic unused_sig;
    assign unused_sig = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                          s00_axi_araddr[1:0], hw_in};

endmodule

// File: tb/tb_coder_axil_regbank.sv
// Directed bench for coder_axil_regbank (8 registers, register 7 read-only).
module tb_coder_axil_regbank;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [255:0] reg_out, hw_in;
    logic [7:0]  wr_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    coder_axil_regbank #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .C_NUM_REGS(8),
        .C_RO_MASK(8'h80)
    ) dut (
        .s00_axi_aclk(clk),       .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid),.s00_axi_awready(awready),
        .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),  .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot),  .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),.s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),    .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),  .reg_out(reg_out),
        .hw_in(hw_in),            .wr_pulse(wr_pulse)
    );

    // Full write transaction with bready high; reports response and pulse activity
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [7:0] pulses, output int pcycles);
        int   cnt;
        logic aw_fire, w_fire;
        cnt = 0; pulses = '0; pcycles = 0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid) && cnt < 40) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk); cnt++;
            if (aw_fire) awvalid = 1'b0;
            if (w_fire)  wvalid  = 1'b0;
            if (wr_pulse != 0) begin pulses |= wr_pulse; pcycles++; end
        end
        while (!bvalid && cnt < 40) begin
            @(negedge clk); cnt++;
            if (wr_pulse != 0) begin pulses |= wr_pulse; pcycles++; end
        end
        total++;
        if (cnt >= 40) begin
            bad++;
            $display("FAIL write_timeout addr=%h got no bvalid within 40 cycles, required bvalid=1", addr);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        resp = bresp;
        @(negedge clk);
        if (wr_pulse != 0) begin pulses |= wr_pulse; pcycles++; end
        bready = 1'b0;
        $display("write addr=%h data=%h strb=%b bresp=%b pulses=%b", addr, data, strb, resp, pulses);
    endtask

    // Full read transaction with rready high
    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int cnt;
        cnt = 0;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!arready && cnt < 40) begin @(negedge clk); cnt++; end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && cnt < 40) begin @(negedge clk); cnt++; end
        total++;
        if (cnt >= 40) begin
            bad++;
            $display("FAIL read_timeout addr=%h got no rvalid within 40 cycles, required rvalid=1", addr);
        end
        data = rdata; resp = rresp;
        @(negedge clk);
        rready = 1'b0;
        $display("read  addr=%h rdata=%h rresp=%b", addr, data, resp);
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_handshake got %b required 00000", {awready, wready, bvalid, arready, rvalid});
        end
        total++;
        if ({bresp, rresp, rdata, wr_pulse} !== 44'h0) begin
            bad++;
            $display("FAIL reset_resp got bresp=%b rresp=%b rdata=%h pulse=%b required all 0", bresp, rresp, rdata, wr_pulse);
        end
        total++;
        if (reg_out !== 256'h0) begin
            bad++;
            $display("FAIL reset_regs got %h required 0", reg_out);
        end
        aresetn = 1'b1;
        $display("reset checked");
    endtask

    task automatic test_basic;
        logic [1:0] resp; logic [7:0] pulses; int pc; logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(4 * i), 32'(i + 1), 4'hF, resp, pulses, pc);
            total++;
            if (resp !== 2'b00 || pulses !== 8'(1 << i) || pc !== 1) begin
                bad++;
                $display("FAIL basic_write%0d got bresp=%b pulses=%b cycles=%0d required 00 %b 1", i, resp, pulses, pc, 8'(1 << i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(4 * i), d, resp);
            total++;
            if (d !== 32'(i + 1) || resp !== 2'b00) begin
                bad++;
                $display("FAIL basic_read%0d got %h/%b required %h/00", i, d, resp, 32'(i + 1));
            end
        end
    endtask

    task automatic test_w_before_aw;
        @(negedge clk);
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        total++;
        if (wready !== 1'b1) begin bad++; $display("FAIL wfirst_wready_idle got %b required 1", wready); end
        @(negedge clk);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({wready, bvalid, awready} !== 3'b001) begin
            bad++;
            $display("FAIL wfirst_waiting got wready,bvalid,awready=%b required 001", {wready, bvalid, awready});
        end
        awaddr = 6'h10; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        total++;
        if ({bvalid, bresp, wr_pulse} !== {1'b1, 2'b00, 8'h10}) begin
            bad++;
            $display("FAIL wfirst_commit got bvalid=%b bresp=%b pulse=%b required 1 00 00010000", bvalid, bresp, wr_pulse);
        end
        @(negedge clk);
        bready = 1'b0;
        total++;
        if ({bvalid, wr_pulse} !== 9'h0 || reg_out[4*32 +: 32] !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL wfirst_after got bvalid=%b pulse=%b reg4=%h required 0 0 a5a5a5a5", bvalid, wr_pulse, reg_out[4*32 +: 32]);
        end
        $display("w-before-aw reg4=%h", reg_out[4*32 +: 32]);
    endtask

    task automatic test_strobe;
        logic [1:0] resp; logic [7:0] pulses; int pc; logic [31:0] d;
        axi_write(6'h08, 32'h11223344, 4'hF, resp, pulses, pc);
        axi_write(6'h08, 32'hAABBCCDD, 4'b0101, resp, pulses, pc);
        axi_read(6'h08, d, resp);
        total++;
        if (d !== 32'h11BB33DD || reg_out[2*32 +: 32] !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL strobe_merge got rdata=%h reg2=%h required 11bb33dd", d, reg_out[2*32 +: 32]);
        end
        axi_write(6'h08, 32'hFFFFFFFF, 4'b0000, resp, pulses, pc);
        total++;
        if (resp !== 2'b00 || pulses !== 8'h04 || reg_out[2*32 +: 32] !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL strobe_zero got bresp=%b pulses=%b reg2=%h required 00 00000100 11bb33dd", resp, pulses, reg_out[2*32 +: 32]);
        end
    endtask

    task automatic test_errors;
        logic [1:0] resp; logic [7:0] pulses; int pc; logic [31:0] d;
        logic [255:0] snap;
        snap = reg_out;
        axi_write(6'h3C, 32'h12345678, 4'hF, resp, pulses, pc);
        total++;
        if (resp !== 2'b10 || pulses !== 8'h00 || reg_out !== snap) begin
            bad++;
            $display("FAIL err_range_write got bresp=%b pulses=%b regs_changed=%b required 10 0 0", resp, pulses, reg_out !== snap);
        end
        axi_read(6'h3C, d, resp);
        total++;
        if (d !== 32'h0 || resp !== 2'b10) begin
            bad++;
            $display("FAIL err_range_read got %h/%b required 00000000/10", d, resp);
        end
        hw_in[7*32 +: 32] = 32'hDEADBEEF;
        axi_write(6'h1C, 32'h0BADF00D, 4'hF, resp, pulses, pc);
        total++;
        if (resp !== 2'b10 || pulses !== 8'h00 || reg_out !== snap) begin
            bad++;
            $display("FAIL err_ro_write got bresp=%b pulses=%b regs_changed=%b required 10 0 0", resp, pulses, reg_out !== snap);
        end
        axi_read(6'h1C, d, resp);
        total++;
        if (d !== 32'hDEADBEEF || resp !== 2'b00 || reg_out[7*32 +: 32] !== 32'h0) begin
            bad++;
            $display("FAIL err_ro_read got %h/%b reg_out7=%h required deadbeef/00 0", d, resp, reg_out[7*32 +: 32]);
        end
        axi_read(6'h0B, d, resp);
        total++;
        if (d !== 32'h11BB33DD || resp !== 2'b00) begin
            bad++;
            $display("FAIL unaligned_read got %h/%b required 11bb33dd/00", d, resp);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] resp; logic [7:0] pulses; int pc; logic [31:0] d;
        @(negedge clk);
        awaddr = 6'h14; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 6'h00; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++;
            $display("FAIL bp_idle_ready got %b required 111", {awready, wready, arready});
        end
        @(negedge clk);
        awaddr = 6'h18; wdata = 32'h66; araddr = 6'h04;
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready}
                !== {1'b1, 2'b00, 1'b1, 2'b00, 32'h1, 3'b000} || reg_out[6*32 +: 32] !== 32'h0) begin
                bad++;
                $display("FAIL bp_hold%0d got b=%b/%b r=%b/%b/%h rdy=%b reg6=%h required 1/00 1/00/00000001 000 0",
                         c, bvalid, bresp, rvalid, rresp, rdata, {awready, wready, arready}, reg_out[6*32 +: 32]);
            end
            @(negedge clk);
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        total++;
        if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111 || reg_out[6*32 +: 32] !== 32'h0) begin
            bad++;
            $display("FAIL bp_release got %b reg6=%h required 00111 0", {bvalid, rvalid, awready, wready, arready}, reg_out[6*32 +: 32]);
        end
        axi_write(6'h18, 32'h66, 4'hF, resp, pulses, pc);
        axi_read(6'h04, d, resp);
        total++;
        if (d !== 32'h2 || reg_out[5*32 +: 32] !== 32'h55 || reg_out[6*32 +: 32] !== 32'h66) begin
            bad++;
            $display("FAIL bp_after got rdata=%h reg5=%h reg6=%h required 2 55 66", d, reg_out[5*32 +: 32], reg_out[6*32 +: 32]);
        end
        $display("backpressure done");
    endtask

    task automatic test_reset_mid;
        logic [1:0] resp; logic [7:0] pulses; int pc; logic [31:0] d;
        int cnt; logic aw_fire, w_fire;
        cnt = 0;
        @(negedge clk);
        awaddr = 6'h00; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        while (!bvalid && cnt < 40) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk); cnt++;
            if (aw_fire) awvalid = 1'b0;
            if (w_fire)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (bvalid !== 1'b1 || reg_out[31:0] !== 32'h5) begin
            bad++;
            $display("FAIL rstmid_pre got bvalid=%b reg0=%h required 1 5", bvalid, reg_out[31:0]);
        end
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        total++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, wr_pulse} !== 48'h0 || reg_out !== 256'h0) begin
            bad++;
            $display("FAIL rstmid_clear got hs=%b bresp=%b rdata=%h pulse=%b reg0=%h required all 0",
                     {awready, wready, bvalid, arready, rvalid}, bresp, rdata, wr_pulse, reg_out[31:0]);
        end
        axi_write(6'h00, 32'h7, 4'hF, resp, pulses, pc);
        total++;
        if (resp !== 2'b00 || pulses !== 8'h01) begin
            bad++;
            $display("FAIL rstmid_write got %b/%b required 00/00000001", resp, pulses);
        end
        axi_read(6'h00, d, resp);
        total++;
        if (d !== 32'h7 || resp !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_read got %h/%b required 7/00", d, resp);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        awaddr = 6'h00; wdata = 32'hAB; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 6'h00; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        total++;
        if ({rvalid, rdata, bvalid, bresp} !== {1'b1, 32'h7, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL collide_read got rvalid=%b rdata=%h bvalid=%b bresp=%b required 1 00000007 1 00", rvalid, rdata, bvalid, bresp);
        end
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        total++;
        if (reg_out[31:0] !== 32'hAB || {bvalid, rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL collide_after got reg0=%h b/r=%b required ab 00", reg_out[31:0], {bvalid, rvalid});
        end
        $display("same-edge read/write reg0=%h", reg_out[31:0]);
    endtask

    initial begin
        aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0; hw_in = '0;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_strobe();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coder_axil_regbank.md
Name: coder_axil_regbank

Overview:
Parametrised AXI4-Lite slave register bank, the successor to the fixed 4-register S00_AXI slave in the coder IP. It provides C_NUM_REGS software-visible registers with per-byte write strobes and per-register read-only masking. Read-only registers are sourced from hardware status inputs. It returns SLVERR on out-of-range or read-only writes and emits a per-register write pulse to the coder datapath. It sits between the MicroBlaze AXI interconnect and the coder core.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; 32 only (byte-lane logic assumes 4 lanes)
C_S_AXI_ADDR_WIDTH, 6, byte address width; register index = addr[C_S_AXI_ADDR_WIDTH-1:2]
C_NUM_REGS, 8, implemented registers, 1..2^(C_S_AXI_ADDR_WIDTH-2)
C_RO_MASK, 8'h00, bit i = 1 makes register i read-only (value taken from hw_in)

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  synchronous active-low reset
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake
s00_axi_bresp  out  2  write response
s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake
reg_out  out  32*C_NUM_REGS  flattened RW register contents, reg i at [32i+31:32i]
hw_in  in  32*C_NUM_REGS  flattened status inputs; used only where C_RO_MASK bit is 1
wr_pulse  out  C_NUM_REGS  one-cycle strobe on each committed write to register i

Behaviour:
- Reset (s00_axi_aresetn = 0 at a rising edge): all registers, awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata and wr_pulse clear to 0 at that edge. Reset asserted mid-transaction aborts the transaction; no response is issued.
- Write FSM states: W_IDLE, W_RESP.
- In W_IDLE, awready = !aw_held and wready = !w_held. AW and W are captured independently, in either order or in the same cycle.
- The write commits at the edge where the second of AW/W is captured (or both together). At that edge: registers update, bvalid goes 1, state moves to W_RESP, and wr_pulse[idx] is high for exactly the following cycle.
- Write latency is 1 cycle from the last handshake to bvalid.
- In W_RESP, awready = wready = 0. bvalid and bresp hold until bvalid & bready. The FSM then returns to W_IDLE, and readies reassert in the next cycle.
- Commit rule per byte lane b with wstrb[b] = 1: reg[idx][8b+7:8b] = wdata[8b+7:8b]. Lanes with strobe 0 are unchanged. wstrb = 0 is a legal no-op: OKAY response and wr_pulse still fires.
- Write errors, bresp = 2'b10 (SLVERR), no register change, no wr_pulse:
  - idx >= C_NUM_REGS
  - C_RO_MASK[idx] = 1
- All other writes return bresp = 2'b00 (OKAY).
- Read FSM states: R_IDLE, R_DATA.
- In R_IDLE, arready = 1. On arvalid & arready, rdata is registered at that edge and rvalid goes 1. Read latency is 1 cycle.
- Read data source:
  - C_RO_MASK[idx] = 0: reg value
  - C_RO_MASK[idx] = 1: hw_in slice sampled at the AR edge
  - idx >= C_NUM_REGS: rdata = 0, rresp = SLVERR
- In R_DATA, arready = 0. rdata, rresp and rvalid hold stable until rvalid & rready, then return to R_IDLE.
- Read and write channels are fully independent and may be active in the same cycle.
- A read capturing at the same edge as a write commit to the same register returns the pre-write value.
- Address bits [1:0] are ignored (unaligned addresses are treated as aligned).
- Address bits above the index width are not decoded.
- reg_out slices for read-only indices are driven 0.

Test Plan:
1. Write 1,2,3,4 to addresses 0x0,0x4,0x8,0xC, then read back -> rdata 1,2,3,4, all bresp/rresp 00, wr_pulse[0..3] each high for one cycle.
2. W presented 3 cycles before AW at address 0x10 with data 0xA5A5A5A5 -> wready low after capture, bvalid exactly 1 cycle after AW handshake, reg4 = 0xA5A5A5A5.
3. reg2 = 0x11223344, then write 0xAABBCCDD with wstrb 4'b0101 -> reg2 = 0x11BB33DD.
4. Write/read address 0x3C with C_NUM_REGS = 8 -> bresp 10, rresp 10, rdata 0, no wr_pulse, no register change. Then set C_RO_MASK = 8'h80, hw_in[7] = 0xDEADBEEF and write 0x1C -> SLVERR, read 0x1C returns 0xDEADBEEF.
5. Hold bready/rready low for 5 cycles -> bvalid/rvalid and data stable throughout, awready/arready low, second AW not accepted until after the B handshake.
6. Deassert aresetn for 1 cycle while bvalid = 1 with reg0 = 0x5 -> next cycle all outputs 0, reg0 = 0, a subsequent write/read to 0x0 completes normally.
